// File: rtl/bstep_pkg.sv
// Shared constants for the binary-step activation scheduler.
package bstep_pkg;

    localparam int unsigned OPERAND_W = 8;

    localparam logic STEP_MODE_EXACT  = 1'b0;
    localparam logic STEP_MODE_APPROX = 1'b1;

endpackage

// File: rtl/bstep_rr_scheduler_if.sv
// Request/response channel between neuron lanes, the scheduler and the result collector.
interface bstep_rr_scheduler_if
    import bstep_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) ();

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [OPERAND_W*NUM_REQ-1:0] req_data;
    logic                         cfg_mode;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic                         rsp_bit;

    modport master (
        output req_valid, req_data, cfg_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_bit
    );

    modport slave (
        input  req_valid, req_data, cfg_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_bit
    );

endinterface

// File: rtl/bstep_core.sv
// Combinational binary-step unit: exact mode tests the sign bit, approximate mode a chosen bit.
module bstep_core
    import bstep_pkg::*;
#(
    parameter int unsigned APPROX_BIT = 0
) (
    input  logic [OPERAND_W-1:0] data_i,
    input  logic                 mode_i,
    output logic                 step_o
);

    // Select the tested bit according to the mode.
    always_comb begin
        step_o = 1'b0;
        case (mode_i)
            STEP_MODE_APPROX: step_o = ~data_i[APPROX_BIT];
            STEP_MODE_EXACT:  step_o = ~data_i[OPERAND_W-1];
            default:          step_o = ~data_i[OPERAND_W-1];
        endcase
    end

endmodule

// File: rtl/bstep_rr_scheduler.sv
// Round-robin scheduler sharing one binary-step core between NUM_REQ lanes,
// with a registered tagged response and a saturating count of one-results.
module bstep_rr_scheduler
    import bstep_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned APPROX_BIT = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    bstep_rr_scheduler_if.slave       bus,
    output logic [CNT_W-1:0]          ones_cnt,
    input  logic                      cnt_clr
);

    localparam logic [ID_W-1:0]  LAST_LANE = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic                 rsp_bit_q, rsp_bit_d;
    logic [CNT_W-1:0]     ones_cnt_q, ones_cnt_d;

    logic                 grant_en_s;
    logic                 grant_valid_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic [OPERAND_W-1:0] core_data_s;
    logic                 core_bit_s;
    logic                 rsp_hs_s;
    int unsigned          lane_s;

    assign grant_en_s = ~rst & (~rsp_valid_q | bus.rsp_ready);
    assign rsp_hs_s   = rsp_valid_q & bus.rsp_ready;

    // Pointer-rotated priority search; scanning from the far end lets the lane
    // nearest the pointer win. Lanes >= NUM_REQ are never visited.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        lane_s        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            lane_s = int'(ptr_q) + k;
            if (lane_s >= NUM_REQ) begin
                lane_s = lane_s - NUM_REQ;
            end else begin
                lane_s = lane_s;
            end
            if (bus.req_valid[lane_s] && grant_en_s) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = lane_s[ID_W-1:0];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // One-hot accept towards the granted lane only.
    always_comb begin
        req_ready_s = '0;
        if (grant_valid_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign core_data_s = bus.req_data[OPERAND_W*int'(grant_idx_s) +: OPERAND_W];

    bstep_core #(
        .APPROX_BIT (APPROX_BIT)
    ) u_core (
        .data_i (core_data_s),
        .mode_i (bus.cfg_mode),
        .step_o (core_bit_s)
    );

    // Response stage and pointer next-state; a grant implies a transfer.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_bit_d   = rsp_bit_q;
        if (grant_valid_s) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx_s;
            rsp_bit_d   = core_bit_s;
            if (grant_idx_s == LAST_LANE) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_s + ID_W'(1);
            end
        end else if (rsp_hs_s) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Saturating ones counter; clear wins over a same-cycle increment.
    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (cnt_clr) begin
            ones_cnt_d = '0;
        end else if (rsp_hs_s && rsp_bit_q && (ones_cnt_q != CNT_MAX)) begin
            ones_cnt_d = ones_cnt_q + CNT_W'(1);
        end else begin
            ones_cnt_d = ones_cnt_q;
        end
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_bit_q   <= 1'b0;
            ones_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_bit_q   <= rsp_bit_d;
            ones_cnt_q  <= ones_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_bit   = rsp_bit_q;
    assign ones_cnt      = ones_cnt_q;

endmodule

// File: tb/tb_bstep_rr_scheduler.sv
// Scoreboard bench for bstep_rr_scheduler against a lane-level round-robin reference model.
module tb_bstep_rr_scheduler;

    localparam int N       = 4;
    localparam int AB      = 0;
    localparam int CW      = 4;
    localparam int CNT_TOP = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] ones_cnt;

    bstep_rr_scheduler_if #(.NUM_REQ(N), .ID_W(2)) bus_if ();

    bstep_rr_scheduler #(
        .NUM_REQ    (N),
        .ID_W       (2),
        .APPROX_BIT (AB),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .ones_cnt (ones_cnt),
        .cnt_clr  (cnt_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: what the DUT should hold after the next rising edge.
    int m_ptr   = 0;
    bit m_valid = 1'b0;
    int m_id    = 0;
    bit m_bit   = 1'b0;
    int m_cnt   = 0;
    int exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ref_step(input logic [7:0] d, input logic mode);
        if (mode) return ((d >> AB) & 8'd1) == 8'd0;
        return $signed(d) >= 0;
    endfunction

    task automatic model_cycle();
        bit free;
        int g;
        int lane;
        logic [7:0] d;
        chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(m_valid));
        chk("rsp_id_state", 32'(bus_if.rsp_id), 32'(m_id));
        chk("rsp_bit_state", 32'(bus_if.rsp_bit), 32'(m_bit));
        chk("ones_cnt", 32'(ones_cnt), 32'(m_cnt));
        free = !m_valid || bus_if.rsp_ready;
        g = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                lane = (m_ptr + k) % N;
                if (g < 0 && bus_if.req_valid[lane]) g = lane;
            end
        end
        chk("req_ready", 32'(bus_if.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (cnt_clr) m_cnt = 0;
        else if (m_valid && bus_if.rsp_ready && m_bit && m_cnt < CNT_TOP) m_cnt++;
        if (g >= 0) begin
            d       = bus_if.req_data[8*g +: 8];
            m_valid = 1'b1;
            m_id    = g;
            m_bit   = ref_step(d, bus_if.cfg_mode);
            m_ptr   = (g + 1) % N;
            exp_q.push_back(m_id * 2 + int'(m_bit));
        end else if (bus_if.rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic mode,
                        input logic rdy, input logic clr);
        @(negedge clk);
        bus_if.req_valid = v;
        bus_if.req_data  = d;
        bus_if.cfg_mode  = mode;
        bus_if.rsp_ready = rdy;
        cnt_clr          = clr;
        #2;
        model_cycle();
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_id    = 0;
        m_bit   = 1'b0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    // Monitor: pops the expected response on every response handshake.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus_if.rsp_valid && bus_if.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(bus_if.rsp_id), 32'(e >> 1));
                    chk("rsp_bit", 32'(bus_if.rsp_bit), 32'(e & 1));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.req_valid = 4'b1111;
        bus_if.req_data  = 32'h0;
        bus_if.cfg_mode  = 1'b0;
        bus_if.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus_if.rsp_id), 32'd0);
        chk("rst_rsp_bit", 32'(bus_if.rsp_bit), 32'd0);
        chk("rst_ones_cnt", 32'(ones_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Fairness: ids 0,1,2,3 repeating, bits 1,0,1,0.
        for (int i = 0; i < 12; i++) step(4'b1111, {8'hFF, 8'h00, 8'h80, 8'h05}, 1'b0, 1'b1, 1'b0);

        // Backpressure with id=2, bit=1 pending, then lane 3 granted on release.
        for (int i = 0; i < 3; i++) step(4'b1111, {8'hFF, 8'h00, 8'h80, 8'h05}, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, {8'hFF, 8'h00, 8'h80, 8'h05}, 1'b0, 1'b0, 1'b0);
            chk("bp_id", 32'(bus_if.rsp_id), 32'd2);
            chk("bp_bit", 32'(bus_if.rsp_bit), 32'd1);
        end
        step(4'b1111, {8'hFF, 8'h00, 8'h80, 8'h05}, 1'b0, 1'b1, 1'b0);
        chk("bp_release_grant", 32'(bus_if.req_ready), 32'b1000);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);

        // Approximate versus exact mode on lane 1.
        step(4'b0010, {8'h00, 8'h00, 8'h7E, 8'h00}, 1'b1, 1'b1, 1'b0);
        step(4'b0010, {8'h00, 8'h00, 8'h7F, 8'h00}, 1'b1, 1'b1, 1'b0);
        chk("approx_7E", 32'(bus_if.rsp_bit), 32'd1);
        step(4'b0010, {8'h00, 8'h00, 8'h7E, 8'h00}, 1'b0, 1'b1, 1'b0);
        chk("approx_7F", 32'(bus_if.rsp_bit), 32'd0);
        step(4'b0010, {8'h00, 8'h00, 8'h7F, 8'h00}, 1'b0, 1'b1, 1'b0);
        chk("exact_7E", 32'(bus_if.rsp_bit), 32'd1);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("exact_7F", 32'(bus_if.rsp_bit), 32'd1);

        // Sparse lanes with pointer wrap 3 -> 0.
        step(4'b0100, 32'h0, 1'b0, 1'b1, 1'b0);
        step(4'b1000, 32'h0, 1'b0, 1'b1, 1'b0);
        step(4'b0001, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("wrap_grant0", 32'(bus_if.req_ready), 32'b0001);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);

        // Counter: five ones, clear racing a ones handshake, then saturation.
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0001, 32'h0, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("cnt_five", 32'(ones_cnt), 32'd5);
        step(4'b0001, 32'h0, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b1);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("cnt_clr_priority", 32'(ones_cnt), 32'd0);
        for (int i = 0; i < 20; i++) step(4'b0001, 32'h0, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("cnt_saturate", 32'(ones_cnt), 32'(CNT_TOP));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        // Reset while a response is pending.
        step(4'b1111, 32'h00FF_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("midrst_ones_cnt", 32'(ones_cnt), 32'd0);
        chk("midrst_req_ready", 32'(bus_if.req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b1111, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_grant", 32'(bus_if.req_ready), 32'b0001);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bstep_rr_scheduler.md
Name: bstep_rr_scheduler

Overview:
Shares one 8-bit binary-step activation unit between NUM_REQ requesters. A round-robin arbiter picks one valid request per cycle and evaluates the step function in the shared core. The result is registered and returned on a single response channel tagged with the requester ID. The block sits between neuron-lane producers and the activation-result collector; it owns the arbitration fairness, backpressure and the result-statistics counter.

Parameters:
NUM_REQ, 4, number of requester lanes (2..8)
ID_W, 2, width of the requester ID; equals ceil(log2(NUM_REQ))
APPROX_BIT, 0, input bit used by the approximate step mode
CNT_W, 16, width of the saturating ones-counter

Ports:
clk  in  1  clock, all state on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-lane request valid
req_ready  out  NUM_REQ  per-lane accept; at most one bit high per cycle
req_data  in  8*NUM_REQ  lane i operand is req_data[8*i+7:8*i], two's complement
cfg_mode  in  1  0 = exact step, 1 = approximate step; sampled with the accepted request
rsp_valid  out  1  response holds a result
rsp_ready  in  1  collector accepts the response
rsp_id  out  ID_W  lane index of the result
rsp_bit  out  1  step-function result
ones_cnt  out  CNT_W  saturating count of accepted responses with rsp_bit=1
cnt_clr  in  1  synchronous clear of ones_cnt

Behaviour:
- Reset (async, active-high): rsp_valid=0, rsp_id=0, rsp_bit=0, ones_cnt=0, RR pointer=0. req_ready is all-zero while rst is high.
- Step function (combinational, in the core):
  - exact mode: out = ~data[7], so 1 when operand >= 0.
  - approx mode: out = ~data[APPROX_BIT].
- Output stage is free when rsp_valid=0 or (rsp_valid & rsp_ready).
- Arbitration, each cycle:
  - If the output stage is free and any req_valid is set, grant the first valid lane at or after the pointer, searching upward with wrap-around.
  - req_ready[g]=1 for the granted lane g only. The grant is combinational from req_valid, rsp_valid, rsp_ready and the pointer.
  - A transfer on lane g occurs when req_valid[g] & req_ready[g].
- On a transfer:
  - Register rsp_valid=1, rsp_id=g, rsp_bit=step(req_data[g], cfg_mode).
  - Pointer becomes (g+1) mod NUM_REQ.
  - Latency is 1 cycle (accept at cycle t, rsp_valid at t+1). Throughput is 1 per cycle while rsp_ready=1.
- No transfer and rsp_valid & rsp_ready: rsp_valid goes to 0. rsp_id and rsp_bit hold their last values.
- rsp_valid & ~rsp_ready: rsp_id and rsp_bit are held stable, and all req_ready are 0.
- A pointer wrap from NUM_REQ-1 goes to 0. The pointer does not move in cycles without a transfer.
- ones_cnt:
  - Increments by 1 on every response handshake (rsp_valid & rsp_ready) with rsp_bit=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- A requester that drops req_valid without a handshake loses nothing. No state is kept per lane.
- Reset mid-transfer discards the pending response; no partial result is emitted after reset.
- NUM_REQ not a power of two: pointer values >= NUM_REQ are unreachable, and the search covers lanes 0..NUM_REQ-1 only.

Decomposition:
- Package bstep_pkg holds:
  - constants STEP_MODE_EXACT=1'b0 and STEP_MODE_APPROX=1'b1
  - the default operand width 8
- One sub-module, bstep_core: 8-bit operand, mode and APPROX_BIT parameter in, 1-bit result out, purely combinational. It is instantiated once in the scheduler.
- The RR grant logic stays inline (pointer-rotated priority encoder).

Test Plan:
- Reset: assert rst mid-stream with rsp_valid=1 -> rsp_valid, ones_cnt and req_ready go to 0 immediately. After release, the first grant goes to lane 0.
- Fairness: all 4 lanes valid continuously, rsp_ready=1, exact mode, data lane0=0x05, lane1=0x80, lane2=0x00, lane3=0xFF:
  - rsp_id sequence is 0,1,2,3,0,…
  - rsp_bit sequence is 1,0,1,0 repeating.
  - One response per cycle after a 1-cycle latency.
- Backpressure: rsp_ready=0 for 3 cycles with a response pending (id=2, bit=1) -> rsp_id and rsp_bit are stable and req_ready=0. When rsp_ready rises, the next grant is lane 3 in the same cycle.
- Approx mode: APPROX_BIT=0, cfg_mode=1, lane1 data 0x7E then 0x7F -> rsp_bit 1 then 0. In exact mode both give 1.
- Sparse and wrap: only lane 3 valid, then only lane 0 valid, pointer at 3 -> grants 3 then 0. The pointer wraps and no idle cycle is inserted.
- Counter: 5 ones-results accepted -> ones_cnt=5. cnt_clr asserted in the same cycle as a ones-handshake -> ones_cnt=0. Preload near saturation (CNT_W=4, 15 ones) -> further ones keep it at 15.
